// File: rtl/awaiba_pkg.sv
// Shared types and defaults for the Awaiba read scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package awaiba_pkg;

  localparam int AWB_DW          = 13;
  localparam int AWB_LINE_LEN    = 250;
  localparam int AWB_FRAME_LINES = 250;
  localparam int AWB_TIMEOUT     = 1024;
  // Widest channel count the scheduler is built for.
  localparam int AWB_NCH_MAX     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2,
    GAP  = 2'd3
  } awb_state_t;

  // Number of participating channels; the caller zero-extends its mask.
  function automatic int unsigned awb_popcount(input logic [AWB_NCH_MAX-1:0] m);
    int unsigned n;
    n = 0;
    for (int i = 0; i < AWB_NCH_MAX; i++) begin
      if (m[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/awaiba_rd_sched_if.sv
// Stream bundle between the channel buffers, the scheduler and the system sink.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the channel side and the system side.
// Ports: ch_valid/ch_data/ch_ready per channel buffer (channel i at [i*DW +: DW]);
//        data_out/valid_out/ready_sys/chan_out/sol/eol towards the system.
interface awaiba_rd_sched_if #(
  parameter int NCH = 4,
  parameter int DW  = awaiba_pkg::AWB_DW
);
  localparam int CW = $clog2(NCH);

  logic [NCH-1:0]    ch_valid;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_ready;

  logic [DW-1:0]     data_out;
  logic              valid_out;
  logic              ready_sys;
  logic [CW-1:0]     chan_out;
  logic              sol;
  logic              eol;

  // Scheduler side.
  modport master (
    input  ch_valid, ch_data, ready_sys,
    output ch_ready, data_out, valid_out, chan_out, sol, eol
  );

  // Environment side: channel buffers plus system sink.
  modport slave (
    output ch_valid, ch_data, ready_sys,
    input  ch_ready, data_out, valid_out, chan_out, sol, eol
  );

endinterface

// File: rtl/awaiba_rr_pick.sv
// Masked round-robin picker: first set mask bit at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none.
// Ports: mask (participating channels), ptr (search start), idx (winner), any (a winner exists).
module awaiba_rr_pick
  import awaiba_pkg::*;
#(
  parameter int NCH = 4,
  localparam int CW = $clog2(NCH)
) (
  input  logic [NCH-1:0] mask,
  input  logic [CW-1:0]  ptr,
  output logic [CW-1:0]  idx,
  output logic           any
);

  localparam int CW1 = CW + 1;

  // One extra bit so ptr+k never wraps before the explicit modulo.
  logic [CW1-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = {1'b0, ptr} + CW1'(k);
      if (cand >= CW1'(NCH)) cand = cand - CW1'(NCH);
      if (!any && mask[cand[CW-1:0]]) begin
        idx = cand[CW-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/awaiba_rd_sched.sv
// Round-robin line scheduler sharing one system stream between NCH sensor channel buffers.
// Latency: zero; the data path is a combinational mux from the granted channel.
// Backpressure: ready_sys is forwarded only to the granted channel; a missing ch_valid for TIMEOUT cycles abandons the line.
// Ports: clk/reset (sync, active high); enable, chan_mask from control; sync to buffers;
//        bus (channel and system streams); frame_done pulse; lost_lines counter; busy.
module awaiba_rd_sched
  import awaiba_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int DW          = AWB_DW,
  parameter int LINE_LEN    = AWB_LINE_LEN,
  parameter int FRAME_LINES = AWB_FRAME_LINES,
  parameter int TIMEOUT     = AWB_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [NCH-1:0]   chan_mask,
  output logic             sync,
  output logic             frame_done,
  output logic [15:0]      lost_lines,
  output logic             busy,
  awaiba_rd_sched_if.master bus
);

  localparam int CW  = $clog2(NCH);
  localparam int WCW = $clog2(LINE_LEN);
  localparam int SCW = $clog2(TIMEOUT);
  localparam int LCW = $clog2(NCH * FRAME_LINES + 1);

  localparam logic [WCW-1:0] WORD_LAST  = WCW'(LINE_LEN - 1);
  localparam logic [SCW-1:0] STALL_LAST = SCW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CH_LAST    = CW'(NCH - 1);

  awb_state_t     state, state_nxt;
  logic [CW-1:0]  sel, sel_nxt;
  logic [CW-1:0]  rr, rr_nxt;
  logic [WCW-1:0] word_cnt, word_nxt;
  logic [SCW-1:0] stall_cnt, stall_nxt;
  logic [LCW-1:0] line_cnt, line_nxt;
  logic [LCW-1:0] line_target;
  logic [15:0]    lost_nxt;
  logic           sync_nxt;

  logic [CW-1:0]  pick_idx;
  logic           pick_any;
  logic           in_xfer;
  logic           sel_valid;
  logic           beat;
  logic           stall;
  logic           last_beat;
  logic           frame_hit;
  logic [CW-1:0]  sel_inc;

  awaiba_rr_pick #(.NCH(NCH)) u_pick (
    .mask (chan_mask),
    .ptr  (rr),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Output mux: the granted channel drives the system stream directly.
  assign in_xfer       = (state == XFER);
  assign sel_valid     = bus.ch_valid[sel];
  assign bus.data_out  = in_xfer ? bus.ch_data[sel*DW +: DW] : '0;
  assign bus.valid_out = in_xfer & sel_valid;
  assign bus.ch_ready  = (in_xfer & bus.ready_sys) ? (NCH'(1) << sel) : '0;
  assign bus.chan_out  = sel;

  assign beat      = bus.valid_out & bus.ready_sys;
  // Only a sink that is ready while the channel has nothing counts as a stall;
  // system backpressure alone must never abandon a line.
  assign stall     = in_xfer & ~sel_valid & bus.ready_sys;
  assign last_beat = (word_cnt == WORD_LAST);
  assign bus.sol   = bus.valid_out & (word_cnt == '0);
  assign bus.eol   = bus.valid_out & last_beat;

  assign sel_inc     = (sel == CH_LAST) ? '0 : sel + 1'b1;
  // Frame length follows the mask as seen in GAP, so it tracks mask changes.
  assign line_target = LCW'(awb_popcount(AWB_NCH_MAX'(chan_mask)) * FRAME_LINES);
  assign frame_hit   = (state == GAP) && (line_cnt == line_target);
  assign frame_done  = frame_hit;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= '0;
      rr         <= '0;
      word_cnt   <= '0;
      stall_cnt  <= '0;
      line_cnt   <= '0;
      lost_lines <= '0;
      sync       <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      rr         <= rr_nxt;
      word_cnt   <= word_nxt;
      stall_cnt  <= stall_nxt;
      line_cnt   <= line_nxt;
      lost_lines <= lost_nxt;
      sync       <= sync_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    rr_nxt    = rr;
    word_nxt  = word_cnt;
    stall_nxt = stall_cnt;
    line_nxt  = line_cnt;
    lost_nxt  = lost_lines;
    sync_nxt  = sync;

    case (state)
      IDLE: begin
        if (enable && (|chan_mask)) begin
          state_nxt = ARB;
          sync_nxt  = 1'b1;
        end
      end

      ARB: begin
        // The mask may have emptied since GAP; fall back to idle rather than
        // granting a channel nobody asked for.
        if (pick_any) begin
          sel_nxt   = pick_idx;
          word_nxt  = '0;
          stall_nxt = '0;
          state_nxt = XFER;
        end else begin
          state_nxt = IDLE;
          sync_nxt  = 1'b0;
        end
      end

      XFER: begin
        if (beat) begin
          stall_nxt = '0;
          if (last_beat) begin
            word_nxt  = '0;
            line_nxt  = line_cnt + 1'b1;
            rr_nxt    = sel_inc;
            state_nxt = GAP;
          end else begin
            word_nxt = word_cnt + 1'b1;
          end
        end else if (stall) begin
          if (stall_cnt == STALL_LAST) begin
            // Abandoned lines still count toward the frame so the frame
            // boundary stays aligned with the sensors.
            stall_nxt = '0;
            lost_nxt  = (lost_lines == 16'hFFFF) ? lost_lines : lost_lines + 16'd1;
            line_nxt  = line_cnt + 1'b1;
            rr_nxt    = sel_inc;
            state_nxt = GAP;
          end else begin
            stall_nxt = stall_cnt + 1'b1;
          end
        end
      end

      GAP: begin
        if (frame_hit) line_nxt = '0;
        if (!enable || !(|chan_mask)) begin
          state_nxt = IDLE;
          sync_nxt  = 1'b0;
        end else begin
          state_nxt = ARB;
        end
      end

      default: begin
        state_nxt = IDLE;
        sync_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_awaiba_rd_sched.sv
// Scoreboard bench for the Awaiba read scheduler (NCH=4, LINE_LEN=4, FRAME_LINES=2, TIMEOUT=16).
// Stimulus pushes expected beats and frame_done points; a negedge monitor pops and compares.
// Channel buffer models return channel*256 + per-channel beat index.
module tb_awaiba_rd_sched;

  localparam int NCH = 4;
  localparam int DW  = 13;

  typedef struct packed {
    logic [1:0]  chan;
    logic [12:0] dat;
    logic        sol;
    logic        eol;
  } beat_t;

  logic           clk;
  logic           reset;
  logic           enable;
  logic [NCH-1:0] chan_mask;
  logic           sync;
  logic           frame_done;
  logic [15:0]    lost_lines;
  logic           busy;

  awaiba_rd_sched_if #(.NCH(NCH), .DW(DW)) bus ();

  awaiba_rd_sched #(
    .NCH(NCH), .DW(DW), .LINE_LEN(4), .FRAME_LINES(2), .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .chan_mask  (chan_mask),
    .sync       (sync),
    .frame_done (frame_done),
    .lost_lines (lost_lines),
    .busy       (busy),
    .bus        (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  beat_t exp_q[$];
  int    fexp_q[$];

  int             beat_total = 0;
  int             mon_sol    = 0;
  int             ch1_cycles = 0;
  logic [NCH-1:0] seen_rdy   = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel buffer models: advance on a handshake seen just before the edge.
  int             cnt [NCH];
  logic [NCH-1:0] adv;
  logic           rst_s;

  task automatic drive_data();
    for (int i = 0; i < NCH; i++) bus.ch_data[i*DW +: DW] = 13'(i*256 + cnt[i]);
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    drive_data();
    forever begin
      @(negedge clk);
      rst_s = reset;
      adv   = reset ? '0 : (bus.ch_ready & bus.ch_valid);
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
        if (rst_s) cnt[i] = 0;
        else if (adv[i]) cnt[i] = cnt[i] + 1;
      end
      drive_data();
    end
  end

  // Monitor: compares every accepted beat and every frame_done pulse.
  initial begin
    beat_t act;
    beat_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        beat_total = 0;
        mon_sol    = 0;
        ch1_cycles = 0;
        seen_rdy   = '0;
      end else begin
        seen_rdy = seen_rdy | bus.ch_ready;
        if (busy && bus.chan_out == 2'd1) ch1_cycles++;
        if (frame_done) begin
          if (fexp_q.size() == 0) check("frame_done_unexpected", 32'(beat_total), 32'hFFFF_FFFF);
          else check("frame_done_at_beat", 32'(beat_total), 32'(fexp_q.pop_front()));
        end
        if (bus.valid_out && bus.ready_sys) begin
          act.chan = bus.chan_out;
          act.dat  = bus.data_out;
          act.sol  = bus.sol;
          act.eol  = bus.eol;
          if (act.sol) mon_sol++;
          if (exp_q.size() == 0) begin
            check("beat_unexpected", 32'(act), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("beat{chan,dat,sol,eol}", 32'(act), 32'(e));
          end
          beat_total++;
        end
      end
    end
  end

  task automatic push_line(input int c, input int k);
    beat_t e;
    for (int b = 0; b < 4; b++) begin
      e.chan = 2'(c);
      e.dat  = 13'(c*256 + 4*k + b);
      e.sol  = (b == 0);
      e.eol  = (b == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic wait_sol(input int n);
    int k;
    k = 0;
    while (mon_sol < n && k < 600) begin tick(); k++; end
    if (mon_sol < n) check("wait_sol_timeout", 32'(mon_sol), 32'(n));
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (beat_total < n && k < 600) begin tick(); k++; end
    if (beat_total < n) check("wait_beats_timeout", 32'(beat_total), 32'(n));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 600) begin tick(); k++; end
    if (busy) check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic end_test(input string name, input int exp_lost);
    check({name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_frames_left"}, 32'(fexp_q.size()), 32'd0);
    check({name, "_lost_lines"}, 32'(lost_lines), 32'(exp_lost));
    exp_q.delete();
    fexp_q.delete();
  endtask

  initial begin
    logic done;
    reset         = 1'b1;
    enable        = 1'b0;
    chan_mask     = 4'b1111;
    bus.ch_valid  = 4'b1111;
    bus.ready_sys = 1'b1;
    repeat (3) tick();

    // Reset state.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sync", 32'(sync), 32'd0);
    check("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check("rst_ch_ready", 32'(bus.ch_ready), 32'd0);
    check("rst_chan_out", 32'(bus.chan_out), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_sol_eol", 32'({bus.sol, bus.eol}), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_lost_lines", 32'(lost_lines), 32'd0);
    reset = 1'b0;
    tick();

    // Full mask: 0,1,2,3,0,1,2,3 then frame_done after 32 beats.
    for (int l = 0; l < 8; l++) push_line(l % 4, l / 4);
    fexp_q.push_back(32);
    enable = 1'b1;
    tick();
    check("run_sync", 32'(sync), 32'd1);
    check("run_busy", 32'(busy), 32'd1);
    wait_sol(8);
    enable = 1'b0;
    wait_idle();
    check("t1_idle_sync", 32'(sync), 32'd0);
    end_test("t1", 0);

    // Mask 0101: channels 0 and 2 alternate, frame after 4 lines.
    do_reset();
    chan_mask = 4'b0101;
    push_line(0, 0); push_line(2, 0); push_line(0, 1); push_line(2, 1);
    fexp_q.push_back(16);
    enable = 1'b1;
    wait_sol(4);
    enable = 1'b0;
    wait_idle();
    check("t2_masked_ready", 32'(seen_rdy & 4'b1010), 32'd0);
    end_test("t2", 0);
    chan_mask = 4'b1111;

    // Toggling system ready plus a 20-cycle hold: no stall, order preserved.
    do_reset();
    push_line(0, 0); push_line(1, 0);
    enable = 1'b1;
    done   = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      tick();
      bus.ready_sys = (cyc >= 6 && cyc < 26) ? 1'b0 : (cyc % 2 == 1);
      if (mon_sol >= 2) enable = 1'b0;
      if (!enable && !busy) done = 1'b1;
    end
    if (!done) check("t3_timeout", 32'(busy), 32'd0);
    bus.ready_sys = 1'b1;
    end_test("t3", 0);

    // Channel 1 never valid: line abandoned after 16 stall cycles, still counts.
    do_reset();
    bus.ch_valid = 4'b1101;
    push_line(0, 0); push_line(2, 0); push_line(3, 0);
    push_line(0, 1); push_line(2, 1); push_line(3, 1);
    fexp_q.push_back(24);
    enable = 1'b1;
    wait_sol(2);
    check("t4_lost_after_first", 32'(lost_lines), 32'd1);
    check("t4_ch1_grant_cycles", 32'(ch1_cycles), 32'd18);
    wait_sol(6);
    enable = 1'b0;
    wait_idle();
    end_test("t4", 2);
    bus.ch_valid = 4'b1111;

    // Enable dropped at beat 1: line completes, idle, resume on next channel.
    do_reset();
    push_line(0, 0);
    enable = 1'b1;
    wait_beats(2);
    enable = 1'b0;
    wait_idle();
    check("t5_idle_sync", 32'(sync), 32'd0);
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_beats_done", 32'(beat_total), 32'd4);
    push_line(1, 0);
    enable = 1'b1;
    wait_sol(2);
    enable = 1'b0;
    wait_idle();
    end_test("t5", 0);

    // Reset at beat 2: outputs drop on the next cycle, restart from channel 0.
    do_reset();
    begin
      beat_t e;
      e = '{chan: 2'd0, dat: 13'd0, sol: 1'b1, eol: 1'b0};
      exp_q.push_back(e);
      e = '{chan: 2'd0, dat: 13'd1, sol: 1'b0, eol: 1'b0};
      exp_q.push_back(e);
    end
    enable = 1'b1;
    wait_beats(2);
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ch_ready", 32'(bus.ch_ready), 32'd0);
    check("t6_sync", 32'(sync), 32'd0);
    check("t6_valid_out", 32'(bus.valid_out), 32'd0);
    check("t6_chan_out", 32'(bus.chan_out), 32'd0);
    check("t6_beats_left", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    push_line(0, 0);
    enable = 1'b1;
    wait_sol(1);
    enable = 1'b0;
    wait_idle();
    end_test("t6", 0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
